// File: rtl/proj_qsys_button_poller.sv
// Polls a 4-bit Avalon-MM button PIO every POLL_PERIOD clocks and reports debounced state and edges.
// Define BUTTON_POLLER_DEBOUNCE_EN to build per-bit debounce counters; otherwise any changed sample is accepted.
module proj_qsys_button_poller #(
  parameter int POLL_PERIOD    = 50000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  address,
  output logic        read,
  input  logic [31:0] readdata,
  output logic [3:0]  buttons_state,
  output logic [3:0]  press_pulse,
  output logic [3:0]  release_pulse,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(POLL_PERIOD + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(POLL_PERIOD - 4);
  localparam logic [3:0] POL_MASK = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_READ   = 2'd1,
    S_LATCH  = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sample_q, sample_d;
  logic [3:0]       btn_q, btn_d;
  logic [3:0]       press_q, press_d;
  logic [3:0]       release_q, release_d;

  logic unused_readdata_hi;
  assign unused_readdata_hi = ^readdata[31:4];

`ifdef BUTTON_POLLER_DEBOUNCE_EN
  logic [3:0][3:0] deb_q, deb_d, deb_inc;

  // Saturating increment so a long-held mismatch never wraps back to zero.
  always_comb begin
    deb_inc = '0;
    for (int i = 0; i < 4; i++) begin
      deb_inc[i] = (deb_q[i] == 4'hF) ? 4'hF : deb_q[i] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_q <= '0;
    else          deb_q <= deb_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
`ifdef BUTTON_POLLER_DEBOUNCE_EN
    deb_d     = deb_q;
`endif
    case (state_q)
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        sample_d = readdata[3:0] ^ POL_MASK;
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
`ifdef BUTTON_POLLER_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
          if (sample_q[i] == btn_q[i]) begin
            deb_d[i] = 4'd0;
          end else if (deb_inc[i] == 4'(DEBOUNCE_COUNT)) begin
            deb_d[i]     = 4'd0;
            btn_d[i]     = ~btn_q[i];
            press_d[i]   = ~btn_q[i];
            release_d[i] = btn_q[i];
          end else begin
            deb_d[i] = deb_inc[i];
          end
        end
`else
        btn_d     = sample_q;
        press_d   = sample_q & ~btn_q;
        release_d = ~sample_q & btn_q;
`endif
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      sample_q  <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign address       = 2'd0;
  assign read          = (state_q == S_READ);
  assign buttons_state = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_proj_qsys_button_poller.sv
// Directed bench for proj_qsys_button_poller with POLL_PERIOD=8, DEBOUNCE_COUNT=3, ACTIVE_LOW=1.
module tb_proj_qsys_button_poller;

  localparam int PP = 8;
  localparam int DC = 3;
`ifdef BUTTON_POLLER_DEBOUNCE_EN
  localparam int NEED = DC;
`else
  localparam int NEED = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic [3:0]  buttons_state;
  logic [3:0]  press_pulse;
  logic [3:0]  release_pulse;
  logic [1:0]  dbg_state;

  logic [3:0] btn_raw;
  int checks;
  int failures;

  proj_qsys_button_poller #(
    .POLL_PERIOD(PP), .DEBOUNCE_COUNT(DC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .readdata(readdata), .buttons_state(buttons_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: latency-1 registered data on a read, random garbage otherwise.
  always @(posedge clk) begin
    if (read) readdata <= {$urandom_range(0, 32'h0FFF_FFFF), btn_raw};
    else      readdata <= $urandom;
  end

  // driver: returns number of negedges after reset release until read is seen
  task automatic release_and_time_first_read(output int k);
    k = -1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (read) begin
        k = i;
        break;
      end
    end
  endtask

  // driver: one poll; returns pulses in the cycle after UPDATE, state, and pulses a cycle later
  task automatic do_poll(input logic [3:0] raw, output logic [3:0] pr, output logic [3:0] rl,
                         output logic [3:0] st, output logic [3:0] after, output bit timeout);
    btn_raw = raw;
    timeout = 1'b1;
    for (int i = 0; i < 3 * PP; i++) begin
      if (read) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);  // LATCH
    @(negedge clk);  // UPDATE
    @(negedge clk);
    pr = press_pulse;
    rl = release_pulse;
    st = buttons_state;
    @(negedge clk);
    after = press_pulse | release_pulse;
  endtask

  task automatic test_reset;
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", read); end
    checks++; if (address !== 2'd0) begin failures++; $display("FAIL reset_address got=%0d exp=0", address); end
    checks++; if (buttons_state !== 4'h0) begin failures++; $display("FAIL reset_state got=%b exp=0000", buttons_state); end
    checks++; if ((press_pulse | release_pulse) !== 4'h0) begin failures++; $display("FAIL reset_pulses got=%b/%b exp=0", press_pulse, release_pulse); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_fsm got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_poll_timing;
    int k;
    int reads;
    int addr_bad;
    int pos[$];
    release_and_time_first_read(k);
    checks++; if (k != PP - 3) begin failures++; $display("FAIL first_read got=%0d exp=%0d", k, PP - 3); end
    reads = 0; addr_bad = 0;
    for (int i = 1; i <= 3 * PP; i++) begin
      @(negedge clk);
      if (read) begin reads++; pos.push_back(i); end
      if (address !== 2'd0) addr_bad++;
    end
    checks++; if (reads != 3) begin failures++; $display("FAIL read_count got=%0d exp=3", reads); end
    checks++; if (pos.size() < 1 || pos[0] != PP) begin failures++; $display("FAIL read_period got=%0d exp=%0d", (pos.size() > 0) ? pos[0] : -1, PP); end
    checks++; if (addr_bad != 0) begin failures++; $display("FAIL address_zero got=%0d bad exp=0", addr_bad); end
  endtask

  task automatic test_press_release;
    logic [3:0] pr, rl, st, af;
    bit to;
    for (int i = 0; i < NEED; i++) begin
      do_poll(4'b1110, pr, rl, st, af, to);
      checks++; if (to) begin failures++; $display("FAIL press_timeout poll=%0d", i); end
      checks++; if (pr !== ((i == NEED - 1) ? 4'b0001 : 4'b0000) || rl !== 4'b0000)
        begin failures++; $display("FAIL press_pulse poll=%0d got=%b/%b exp=%b/0000", i, pr, rl, (i == NEED - 1) ? 4'b0001 : 4'b0000); end
      checks++; if (af !== 4'b0000) begin failures++; $display("FAIL press_one_cycle got=%b exp=0000", af); end
    end
    checks++; if (st !== 4'b0001) begin failures++; $display("FAIL press_state got=%b exp=0001", st); end
    for (int i = 0; i < NEED; i++) begin
      do_poll(4'b1111, pr, rl, st, af, to);
      checks++; if (rl !== ((i == NEED - 1) ? 4'b0001 : 4'b0000) || pr !== 4'b0000)
        begin failures++; $display("FAIL release_pulse poll=%0d got=%b/%b", i, pr, rl); end
    end
    checks++; if (st !== 4'b0000) begin failures++; $display("FAIL release_state got=%b exp=0000", st); end
  endtask

  task automatic test_glitch;
    logic [3:0] pr, rl, st, af;
    bit to;
`ifdef BUTTON_POLLER_DEBOUNCE_EN
    for (int i = 0; i < DC - 1; i++) begin
      do_poll(4'b1110, pr, rl, st, af, to);
      checks++; if ((pr | rl) !== 4'b0000) begin failures++; $display("FAIL glitch_pulse poll=%0d got=%b/%b exp=0", i, pr, rl); end
    end
    do_poll(4'b1111, pr, rl, st, af, to);
    checks++; if ((pr | rl) !== 4'b0000 || st !== 4'b0000) begin failures++; $display("FAIL glitch_end got=%b/%b st=%b exp=0", pr, rl, st); end
    // counter must have cleared: another DC-1 low polls still give nothing
    for (int i = 0; i < DC - 1; i++) begin
      do_poll(4'b1110, pr, rl, st, af, to);
      checks++; if ((pr | rl) !== 4'b0000) begin failures++; $display("FAIL glitch_clear poll=%0d got=%b/%b", i, pr, rl); end
    end
    do_poll(4'b1111, pr, rl, st, af, to);
`else
    do_poll(4'b1011, pr, rl, st, af, to);
    checks++; if (pr !== 4'b0100 || rl !== 4'b0000) begin failures++; $display("FAIL glitch_press got=%b/%b exp=0100/0000", pr, rl); end
    do_poll(4'b1111, pr, rl, st, af, to);
    checks++; if (rl !== 4'b0100 || pr !== 4'b0000) begin failures++; $display("FAIL glitch_release got=%b/%b exp=0000/0100", pr, rl); end
`endif
    checks++; if (st !== 4'b0000) begin failures++; $display("FAIL glitch_state got=%b exp=0000", st); end
  endtask

  task automatic test_multi;
    logic [3:0] pr, rl, st, af;
    bit to;
    for (int i = 0; i < NEED; i++) do_poll(4'b0101, pr, rl, st, af, to);
    checks++; if (pr !== 4'b1010 || rl !== 4'b0000) begin failures++; $display("FAIL multi_press got=%b/%b exp=1010/0000", pr, rl); end
    checks++; if (st !== 4'b1010) begin failures++; $display("FAIL multi_state got=%b exp=1010", st); end
    for (int i = 0; i < NEED; i++) do_poll(4'b1111, pr, rl, st, af, to);
    checks++; if (rl !== 4'b1010 || pr !== 4'b0000) begin failures++; $display("FAIL multi_release got=%b/%b exp=0000/1010", pr, rl); end
    checks++; if (st !== 4'b0000) begin failures++; $display("FAIL multi_rel_state got=%b exp=0000", st); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] pr, rl, st, af;
    bit to;
    int k;
    for (int i = 0; i < NEED - 1; i++) do_poll(4'b1110, pr, rl, st, af, to);
    btn_raw = 4'b1110;
    for (int i = 0; i < 3 * PP && !read; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL mid_in_latch got=%0d exp=2", dbg_state); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({read, address, buttons_state, press_pulse, release_pulse, dbg_state} !== 17'd0)
      begin failures++; $display("FAIL mid_reset_outputs got=%b exp=0", {read, address, buttons_state, press_pulse, release_pulse, dbg_state}); end
    release_and_time_first_read(k);
    checks++; if (k != PP - 3) begin failures++; $display("FAIL mid_first_read got=%0d exp=%0d", k, PP - 3); end
    for (int i = 0; i < NEED; i++) begin
      do_poll(4'b1110, pr, rl, st, af, to);
      checks++; if (pr !== ((i == NEED - 1) ? 4'b0001 : 4'b0000) || rl !== 4'b0000)
        begin failures++; $display("FAIL mid_restart poll=%0d got=%b/%b", i, pr, rl); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    btn_raw = 4'hF;
    repeat (3) @(negedge clk);
    test_reset;
    test_poll_timing;
    test_press_release;
    test_glitch;
    test_multi;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
